// File: rtl/rr_mux16.sv
// 16-to-1 round-robin channel collector: merges 16 valid/ready sources into one
// registered output stream tagged with the 4-bit index of the supplying channel.
module rr_mux16 #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           in_valid,
   input  logic [16*WIDTH-1:0]   in_data,
   output logic [15:0]           in_ready,
   input  logic [15:0]           chan_en,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [3:0]            out_sel,
   input  logic                  out_ready,
   output logic                  busy
);

   logic [3:0]       r_ptr;
   logic             r_outValid;
   logic [WIDTH-1:0] r_outData;
   logic [3:0]       r_outSel;

   logic [15:0]      w_req;
   logic             w_load;
   logic             w_grantValid;
   logic [3:0]       w_grantIdx;
   logic [3:0]       w_scanIdx;
   logic             w_xfer;

   assign w_req  = in_valid & chan_en;
   assign w_load = !r_outValid || out_ready;

   // Scan from the farthest offset down to offset 0 so the nearest request at or
   // after r_ptr is the last one written and therefore wins.
   always_comb begin
      w_grantValid = 1'b0;
      w_grantIdx   = 4'd0;
      w_scanIdx    = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         w_scanIdx = r_ptr + 4'(i);
         if (w_req[w_scanIdx]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = w_scanIdx;
         end
      end
   end

   assign w_xfer   = rst_n && w_load && w_grantValid;
   assign in_ready = w_xfer ? (16'h0001 << w_grantIdx) : 16'h0000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= 4'd0;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outSel   <= 4'd0;
      end else if (w_xfer) begin
         r_ptr      <= w_grantIdx + 4'd1;
         r_outValid <= 1'b1;
         r_outData  <= in_data[w_grantIdx*WIDTH +: WIDTH];
         r_outSel   <= w_grantIdx;
      end else if (r_outValid && out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign out_sel   = r_outSel;
   assign busy      = (|w_req) || r_outValid;

endmodule

// File: tb/tb_rr_mux16.sv
// Self-checking bench for rr_mux16: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin reference model.
module tb_rr_mux16;

   logic          clk;
   logic          rst_n;
   logic [15:0]   in_valid;
   logic [127:0]  in_data;
   logic [15:0]   in_ready;
   logic [15:0]   chan_en;
   logic          out_valid;
   logic [7:0]    out_data;
   logic [3:0]    out_sel;
   logic          out_ready;
   logic          busy;

   int errors;
   int checks;

   // Reference model state
   int        mPtr;
   bit        mValid;
   logic [7:0] mData;
   int        mSel;

   rr_mux16 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .chan_en   (chan_en),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // First requesting channel found walking upward from ptr with wraparound; -1 if none
   function automatic int modelGrant(input logic [15:0] req, input int ptr);
      int g;
      g = -1;
      for (int k = 0; k < 16; k++) begin
         if (g < 0 && req[(ptr + k) % 16]) g = (ptr + k) % 16;
      end
      return g;
   endfunction

   function automatic logic [15:0] modelReady();
      int g;
      logic [15:0] r;
      r = 16'h0000;
      g = modelGrant(in_valid & chan_en, mPtr);
      if (rst_n && (!mValid || out_ready) && g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task automatic modelReset();
      mPtr   = 0;
      mValid = 0;
      mData  = 8'h00;
      mSel   = 0;
   endtask

   // Advance one clock edge, updating the model from the inputs seen at that edge
   task automatic tick();
      int g;
      bit ld;
      g  = modelGrant(in_valid & chan_en, mPtr);
      ld = !mValid || out_ready;
      @(posedge clk);
      if (rst_n) begin
         if (ld && g >= 0) begin
            mValid = 1;
            mData  = in_data[g*8 +: 8];
            mSel   = g;
            mPtr   = (g + 1) % 16;
         end else if (mValid && out_ready) begin
            mValid = 0;
         end
      end
      #1;
   endtask

   task automatic doReset();
      in_valid  = 16'h0000;
      chan_en   = 16'hFFFF;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic setRampData();
      for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
   endtask

   task automatic test_reset();
      in_valid  = 16'hFFFF;
      chan_en   = 16'hFFFF;
      out_ready = 1'b1;
      in_data   = '0;
      rst_n     = 1'b0;
      modelReset();
      #7;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got valid=%b data=%h sel=%0d expected 0/00/0", out_valid, out_data, out_sel);
      end
      checks++;
      if (in_ready !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_in_ready: got %h expected 0000", in_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 16'h0000;
   endtask

   task automatic test_single();
      doReset();
      in_data[5*8 +: 8] = 8'hA5;
      in_valid = 16'h0020;
      #1;
      checks++;
      if (in_ready !== 16'h0020) begin
         errors++;
         $display("[TB] FAIL single_ready: got %h expected 0020", in_ready);
      end
      tick();
      in_valid = 16'h0000;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 4'd5) begin
         errors++;
         $display("[TB] FAIL single_out: got valid=%b data=%h sel=%0d expected 1/a5/5", out_valid, out_data, out_sel);
      end
      checks++;
      if (in_ready !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL single_ready_drop: got %h expected 0000", in_ready);
      end
      // Pointer now sits at 6, so channel 6 must beat channel 5
      in_valid = 16'h0060;
      #1;
      checks++;
      if (in_ready !== 16'h0040) begin
         errors++;
         $display("[TB] FAIL single_ptr6: got %h expected 0040", in_ready);
      end
      tick();
      in_valid = 16'h0000;
   endtask

   task automatic test_back_to_back();
      doReset();
      setRampData();
      in_valid = 16'hFFFF;
      for (int k = 0; k < 32; k++) begin
         #1;
         checks++;
         if (in_ready !== (16'h0001 << (k % 16))) begin
            errors++;
            $display("[TB] FAIL b2b_ready[%0d]: got %h expected %h", k, in_ready, 16'h0001 << (k % 16));
         end
         if (k > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 4'((k - 1) % 16) || out_data !== 8'(8'h10 + (k - 1) % 16)) begin
               errors++;
               $display("[TB] FAIL b2b_out[%0d]: got valid=%b sel=%0d data=%h expected 1/%0d/%h",
                        k, out_valid, out_sel, out_data, (k - 1) % 16, 8'(8'h10 + (k - 1) % 16));
            end
         end
         tick();
      end
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 4'd15 || out_data !== 8'h1F) begin
         errors++;
         $display("[TB] FAIL b2b_last: got valid=%b sel=%0d data=%h expected 1/15/1f", out_valid, out_sel, out_data);
      end
      in_valid = 16'h0000;
      tick();
   endtask

   task automatic test_stall();
      doReset();
      setRampData();
      in_valid  = 16'h1008;
      out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 16'h0008) begin
         errors++;
         $display("[TB] FAIL stall_first_ready: got %h expected 0008", in_ready);
      end
      tick();
      in_valid = 16'h1000;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_sel !== 4'd3 || in_ready !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL stall_hold[%0d]: got valid=%b sel=%0d ready=%h expected 1/3/0000",
                     k, out_valid, out_sel, in_ready);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 16'h1000) begin
         errors++;
         $display("[TB] FAIL stall_release_ready: got %h expected 1000", in_ready);
      end
      tick();
      in_valid = 16'h0000;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 4'd12 || out_data !== 8'h1C) begin
         errors++;
         $display("[TB] FAIL stall_next: got valid=%b sel=%0d data=%h expected 1/12/1c", out_valid, out_sel, out_data);
      end
      tick();
   endtask

   task automatic test_mask();
      logic [15:0] expReady;
      doReset();
      setRampData();
      in_valid = 16'hFFFF;
      chan_en  = 16'h8001;
      for (int k = 0; k < 8; k++) begin
         expReady = (k % 2 == 0) ? 16'h0001 : 16'h8000;
         #1;
         checks++;
         if (in_ready !== expReady || in_ready[14:1] !== 14'h0) begin
            errors++;
            $display("[TB] FAIL mask_ready[%0d]: got %h expected %h", k, in_ready, expReady);
         end
         tick();
         checks++;
         if (out_sel !== ((k % 2 == 0) ? 4'd0 : 4'd15)) begin
            errors++;
            $display("[TB] FAIL mask_sel[%0d]: got %0d expected %0d", k, out_sel, (k % 2 == 0) ? 0 : 15);
         end
      end
      in_valid = 16'h0000;
      chan_en  = 16'hFFFF;
      tick();
   endtask

   task automatic test_async_reset();
      doReset();
      setRampData();
      in_valid = 16'h0080;
      tick();
      in_valid = 16'h0000;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 4'd7) begin
         errors++;
         $display("[TB] FAIL areset_pre: got valid=%b sel=%0d expected 1/7", out_valid, out_sel);
      end
      #1;
      rst_n = 1'b0;
      modelReset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL areset_immediate: got valid=%b ready=%h expected 0/0000", out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 16'h0204;
      #1;
      checks++;
      if (in_ready !== 16'h0004) begin
         errors++;
         $display("[TB] FAIL areset_first_ready: got %h expected 0004", in_ready);
      end
      tick();
      in_valid = 16'h0200;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 4'd2 || out_data !== 8'h12) begin
         errors++;
         $display("[TB] FAIL areset_first_grant: got valid=%b sel=%0d data=%h expected 1/2/12", out_valid, out_sel, out_data);
      end
      tick();
      in_valid = 16'h0000;
      tick();
   endtask

   task automatic test_pulse();
      doReset();
      setRampData();
      in_valid = 16'h0001;
      #1;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pulse_c0: got busy=%b valid=%b expected 1/0", busy, out_valid);
      end
      tick();
      in_valid = 16'h0000;
      #1;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h10) begin
         errors++;
         $display("[TB] FAIL pulse_c1: got busy=%b valid=%b data=%h expected 1/1/10", busy, out_valid, out_data);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h10) begin
            errors++;
            $display("[TB] FAIL pulse_idle[%0d]: got busy=%b valid=%b data=%h expected 0/0/10", k, busy, out_valid, out_data);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [15:0] expReady;
      doReset();
      for (int k = 0; k < 400; k++) begin
         in_valid  = 16'($urandom) & 16'($urandom);
         chan_en   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         #1;
         expReady = modelReady();
         checks++;
         if (in_ready !== expReady) begin
            errors++;
            $display("[TB] FAIL rand_ready[%0d]: got %h expected %h", k, in_ready, expReady);
         end
         checks++;
         if (busy !== ((|(in_valid & chan_en)) || mValid)) begin
            errors++;
            $display("[TB] FAIL rand_busy[%0d]: got %b expected %b", k, busy, (|(in_valid & chan_en)) || mValid);
         end
         checks++;
         if (out_valid !== mValid || (mValid && (out_data !== mData || out_sel !== 4'(mSel)))) begin
            errors++;
            $display("[TB] FAIL rand_out[%0d]: got valid=%b data=%h sel=%0d expected %b/%h/%0d",
                     k, out_valid, out_data, out_sel, mValid, mData, mSel);
         end
         tick();
      end
      in_valid = 16'h0000;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst_n     = 1'b0;
      in_valid  = 16'h0000;
      chan_en   = 16'hFFFF;
      in_data   = '0;
      out_ready = 1'b1;
      modelReset();
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_mask();
      test_async_reset();
      test_pulse();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_mux16.md
Name: rr_mux16

Overview:
- 16-to-1 arbitrated channel collector. It merges 16 independent valid/ready source channels onto one registered output stream.
- Serves as the gathering end of the 1x16 distribution path. A 4-bit select fans one stream out to 16 lanes; this block merges 16 lanes back into one stream and reports the 4-bit source index with each word.
- Arbitration is round-robin and fair. Output is registered, with one cycle of latency and full throughput.

Parameters:
- WIDTH, 8, data width per channel.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 16, per-channel valid; bit i belongs to channel i.
- in_data, input, 16*WIDTH, flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready, output, 16, per-channel accept; at most one bit high; combinational.
- chan_en, input, 16, channel enable mask; a channel with its bit at 0 is never granted.
- out_valid, output, 1, output register holds a word.
- out_data, output, WIDTH, registered word.
- out_sel, output, 4, index of the channel that supplied out_data.
- out_ready, input, 1, downstream accept.
- busy, output, 1, high when any enabled channel is requesting or out_valid is 1.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - out_valid = 0, out_data = 0, out_sel = 0.
  - ptr = 0 (internal 4-bit round-robin start pointer).
  - in_ready = 0 while rst_n is low.
- Request vector: req = in_valid & chan_en.
- Load enable: load = !out_valid || out_ready. An empty register, or one draining this cycle, may reload in the same cycle.
- Grant, combinational:
  - Search req starting at index ptr, ascending, wrapping 15 -> 0.
  - The first set bit is channel g. No set bit means no grant.
- in_ready[g] = load && (a grant exists). All other in_ready bits are 0. in_ready never depends on in_valid of a channel other than through the grant search.
- Transfer at a posedge when in_ready[g] is 1:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - ptr <= g+1 mod 16
- Drain: if out_valid && out_ready and no grant exists, out_valid <= 0. out_data and out_sel hold their last values.
- Stall: if out_valid && !out_ready, out_valid, out_data and out_sel hold, and all in_ready bits are 0.
- Latency: input accept to out_valid is 1 cycle. Sustained throughput is 1 word/cycle while out_ready = 1.
- Fairness: with all 16 channels continuously valid and out_ready = 1, grants follow 0,1,...,15,0,... A channel waits at most 15 other transfers.
- ptr advances only on a transfer, never on stall or drain.
- chan_en changes take effect in the same cycle's grant search. Clearing a bit does not disturb a word already held in the output register.
- Source rule: a source must hold in_valid and in_data stable until its in_ready is seen high. The block does not check this.
- busy = (|req) || out_valid, combinational.
- Reset mid-operation: the held word is discarded, out_valid goes 0 immediately (asynchronously), and ptr returns to 0. The first grant after reset release goes to the lowest requesting index.

Test Plan:
1. Reset, then channel 5 only valid with data 0xA5 and out_ready = 1 -> in_ready = 16'h0020 for one cycle; next cycle out_valid = 1, out_data = 0xA5, out_sel = 5; ptr = 6.
2. All 16 channels valid, data = 0x10+i, chan_en = 16'hFFFF, out_ready = 1 for 32 cycles -> out_sel sequence 0..15,0..15 with no bubbles; out_data = 0x10+out_sel.
3. Channels 3 and 12 valid, out_ready held 0 after the first grant -> out_sel = 3 held with out_valid = 1 and in_ready = 0 throughout the stall. Raise out_ready -> next word has out_sel = 12 in the same cycle the first word drains.
4. All valid, chan_en = 16'h8001 -> grants alternate 0,15,0,15; in_ready bits 1..14 never assert.
5. Channel 7 word accepted, then pulse rst_n low asynchronously mid-cycle -> out_valid = 0 before the next clk edge. After release, with channels 2 and 9 valid, the first grant is 2.
6. Single valid pulse on channel 0 with out_ready = 1 -> out_valid high for exactly one cycle; busy high for 2 cycles, then 0.
